// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and FSM state encodings.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, built as a full-adder ripple chain on ~D with carry-in 1.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p_shifted_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] d_inv;
  logic [WIDTH:0] carry;
  logic [WIDTH:0] trial;

  assign d_inv    = ~{1'b0, d_i};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign trial[i] = p_shifted_i[i] ^ d_inv[i] ^ carry[i];
    if (i < WIDTH) begin : g_carry
      assign carry[i+1] = (p_shifted_i[i] & d_inv[i]) |
                          (p_shifted_i[i] & carry[i]) |
                          (d_inv[i]       & carry[i]);
    end
  end

  // A clear sign bit means the divisor fit; otherwise restore the shifted value.
  assign q_bit_o  = ~trial[WIDTH];
  assign p_next_o = q_bit_o ? trial : p_shifted_i;

endmodule

// File: rtl/four_bit_divider.sv
// Sequential unsigned restoring divider: accepts dividend/divisor on start,
// retires one quotient bit per clock and strobes done with the results.
module four_bit_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [2*WIDTH:0] pq_shift;
  logic [WIDTH:0]   p_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_new;

  assign pq_shift = {p_q, q_q} << 1;
  assign q_new    = pq_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, q_bit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_shifted_i (pq_shift[2*WIDTH:WIDTH]),
    .d_i         (d_q),
    .p_next_o    (p_next),
    .q_bit_o     (q_bit)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d = state_q;
    q_d     = q_q;
    p_d     = p_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = ST_RUN;
            q_d     = dividend;
            p_d     = '0;
            d_d     = divisor;
            cnt_d   = CNT_W'(WIDTH - 1);
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        p_d    = p_next;
        q_d    = q_new;
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quot_d  = q_new;
          rem_d   = p_next[WIDTH-1:0];
          dbz_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge, and every register, including
  // the Q/P/D working set, is cleared so a discarded operation leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      p_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      p_q     <= p_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_four_bit_divider.sv
// Directed scoreboard bench for four_bit_divider: expected results are queued
// at start and compared when done strobes; latency and busy are tracked per cycle.
module tb_four_bit_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  four_bit_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
  endtask

  // Called in the start cycle; returns in the done cycle without advancing past it.
  // poke > 0 re-pulses start with different operands in that cycle of the run.
  task automatic wait_done(input string tag, input int exp_lat, input int poke);
    int   n;
    exp_t e;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 16) begin
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_lat > 1});
      if (n == poke) begin
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sb_pending"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, {28'd0, quotient}, {28'd0, e.q});
      chk({tag, "_remainder"}, {28'd0, remainder}, {28'd0, e.r});
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
    end
  endtask

  task automatic after_done(input string tag, input logic [W-1:0] q_hold);
    tick();
    chk({tag, "_done_drop"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "_q_hold"}, {28'd0, quotient}, {28'd0, q_hold});
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("reset_outputs", {21'd0, quotient, remainder, busy, done, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    issue(4'd13, 4'd3);  wait_done("d13_3", 5, 0);  after_done("d13_3", 4'd4);
    issue(4'd15, 4'd1);  wait_done("d15_1", 5, 0);  after_done("d15_1", 4'd15);
    issue(4'd7, 4'd9);   wait_done("d7_9", 5, 0);   after_done("d7_9", 4'd0);
    issue(4'd0, 4'd5);   wait_done("d0_5", 5, 0);   after_done("d0_5", 4'd0);
    issue(4'd9, 4'd0);   wait_done("d9_0", 1, 0);   after_done("d9_0", 4'd15);
    issue(4'd12, 4'd5);  wait_done("d12_5", 5, 2);  after_done("d12_5", 4'd2);

    // Reset asserted mid-run discards the operation without a done strobe.
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrun_reset_outputs", {21'd0, quotient, remainder, busy, done, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrun_no_done", {30'd0, done, busy}, 32'd0);
    end

    issue(4'd11, 4'd2);  wait_done("b2b_first", 5, 0);
    issue(4'd8, 4'd3);   wait_done("b2b_second", 5, 0);  after_done("b2b_second", 4'd2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Continuous guard: busy and done must never coincide.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1 && done === 1'b1) begin
      tests++;
      fails++;
      $error("FAIL busy_done_overlap: observed busy=%b done=%b expected not both", busy, done);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
